// File: rtl/fifo_reader_pkg.sv
// ---------------------------------------------------------------------------
// fifo_reader_pkg
// Shared definitions for the FIFO burst reader and its skid buffer.
//   readerState_e : burst FSM encoding (IDLE / READ / DRAIN / DONE)
//   SKID_DEPTH    : number of entries in the output skid buffer
//   OCC_WIDTH     : width of occupancy count and buffer pointers
//   nextPtr()     : wrap-around increment for a SKID_DEPTH-entry ring
// ---------------------------------------------------------------------------
package fifo_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } readerState_e;

  localparam int SKID_DEPTH = 3;
  localparam int OCC_WIDTH  = 2;

  localparam logic [OCC_WIDTH-1:0] OCC_FULL = OCC_WIDTH'(SKID_DEPTH);
  localparam logic [OCC_WIDTH-1:0] PTR_LAST = OCC_WIDTH'(SKID_DEPTH - 1);

  // Ring pointers wrap at SKID_DEPTH rather than at a power of two, so the
  // increment has to fold back to zero explicitly after the last slot.
  function automatic logic [OCC_WIDTH-1:0] nextPtr(input logic [OCC_WIDTH-1:0] ptr);
    return (ptr == PTR_LAST) ? '0 : ptr + OCC_WIDTH'(1);
  endfunction

endpackage

// File: rtl/fifo_skid_buffer.sv
// ---------------------------------------------------------------------------
// fifo_skid_buffer
// Small circular buffer that absorbs words already requested from the FIFO
// while the downstream consumer is stalled.
// Ports:
//   clk, reset     : clock and synchronous active-high reset
//   enable_i       : all state changes gated by this (clock enable)
//   push_i         : write pushData_i into the tail this cycle
//   pushData_i     : word to store
//   pop_i          : remove the head word this cycle
//   occ_o          : number of stored words (0..SKID_DEPTH)
//   headData_o     : oldest stored word, zero when empty
// ---------------------------------------------------------------------------
module fifo_skid_buffer
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] pushData_i,
  input  logic                  pop_i,
  output logic [OCC_WIDTH-1:0]  occ_o,
  output logic [DATA_WIDTH-1:0] headData_o
);

  logic [DATA_WIDTH-1:0] mem_q [0:SKID_DEPTH-1];
  logic [OCC_WIDTH-1:0]  wrPtr_q, wrPtr_d;
  logic [OCC_WIDTH-1:0]  rdPtr_q, rdPtr_d;
  logic [OCC_WIDTH-1:0]  occ_q, occ_d;
  logic                  doPush, doPop;

  // Decide which of push/pop actually take effect and derive the next
  // pointer and occupancy values. A push into a full buffer is only allowed
  // when a pop frees a slot at the same edge; a simultaneous push and pop
  // leaves the occupancy unchanged.
  always_comb begin
    doPop   = pop_i && (occ_q != '0);
    doPush  = push_i && ((occ_q != OCC_FULL) || doPop);
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    occ_d   = occ_q;
    if (doPush) wrPtr_d = nextPtr(wrPtr_q);
    if (doPop)  rdPtr_d = nextPtr(rdPtr_q);
    if (doPush && !doPop) begin
      occ_d = occ_q + OCC_WIDTH'(1);
    end else if (doPop && !doPush) begin
      occ_d = occ_q - OCC_WIDTH'(1);
    end
  end

  // Pointer and occupancy registers. Reset empties the buffer; with the
  // enable low everything holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      occ_q   <= '0;
    end else if (enable_i) begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      occ_q   <= occ_d;
    end
  end

  // Storage array. Contents need no reset because the head output is
  // masked whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (!reset && enable_i && doPush) begin
      mem_q[wrPtr_q] <= pushData_i;
    end
  end

  assign occ_o      = occ_q;
  assign headData_o = (occ_q != '0) ? mem_q[rdPtr_q] : '0;

endmodule

// File: rtl/fifo_burst_reader.sv
// ---------------------------------------------------------------------------
// fifo_burst_reader
// Read-side master for fifo_generic. A start pulse launches a burst that pops
// exactly burst_len words from the FIFO and streams them out in order on a
// valid/ready interface. A 3-entry skid buffer hides the FIFO's one-cycle
// read latency so the block sustains one word per clock, and fifo_read never
// depends combinationally on out_ready.
// Ports:
//   clk, reset      : clock, synchronous active-high reset (beats clk_enable)
//   clk_enable      : state advances only when high
//   start           : one-cycle burst request, ignored while busy
//   burst_len       : number of words in the burst, sampled with start
//   fifo_read       : read strobe to the FIFO
//   fifo_read_data  : FIFO data, valid the cycle after fifo_read
//   fifo_empty      : FIFO empty flag
//   out_valid/out_ready/out_data : output stream
//   busy            : burst in progress
//   done            : one-cycle pulse once the last word has left
//   words_left      : words not yet requested from the FIFO
// ---------------------------------------------------------------------------
module fifo_burst_reader
  import fifo_reader_pkg::*;
#(
  parameter int FIFO_DATA_WIDTH = 8,
  parameter int LEN_WIDTH       = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clk_enable,
  input  logic                       start,
  input  logic [LEN_WIDTH-1:0]       burst_len,
  output logic                       fifo_read,
  input  logic [FIFO_DATA_WIDTH-1:0] fifo_read_data,
  input  logic                       fifo_empty,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [FIFO_DATA_WIDTH-1:0] out_data,
  output logic                       busy,
  output logic                       done,
  output logic [LEN_WIDTH-1:0]       words_left
);

  readerState_e          state_q, state_d;
  logic [LEN_WIDTH-1:0]  wordsLeft_q, wordsLeft_d;
  logic                  inflight_q, inflight_d;
  logic [OCC_WIDTH-1:0]  occ;
  logic [OCC_WIDTH:0]    pending;

  // Words already committed to the buffer: stored ones plus the one whose
  // FIFO data arrives at the next edge. Issuing a read only while this is
  // below the buffer depth guarantees every returning word has a slot even
  // if the consumer stalls, without looking at out_ready.
  assign pending = {1'b0, occ} + {{OCC_WIDTH{1'b0}}, inflight_q};

  // Next-state, read-issue and done logic. Defaults hold every register,
  // which is also the complete behaviour while clk_enable is low.
  always_comb begin
    state_d     = state_q;
    wordsLeft_d = wordsLeft_q;
    inflight_d  = inflight_q;
    fifo_read   = 1'b0;
    done        = 1'b0;
    if (clk_enable) begin
      fifo_read  = (state_q == READ) && !fifo_empty && (wordsLeft_q != '0)
                   && (pending < (OCC_WIDTH+1)'(SKID_DEPTH));
      inflight_d = fifo_read;
      if (fifo_read) wordsLeft_d = wordsLeft_q - LEN_WIDTH'(1);
      done = (state_q == DONE);
      case (state_q)
        IDLE: begin
          if (start) begin
            wordsLeft_d = burst_len;
            state_d     = (burst_len == '0) ? DONE : READ;
          end
        end
        READ: begin
          if (wordsLeft_q == '0) state_d = DRAIN;
        end
        DRAIN: begin
          if (!inflight_q && (occ == '0)) state_d = DONE;
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // FSM, burst counter and in-flight flag. Reset drops any word still in
  // flight from the FIFO by clearing the flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wordsLeft_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wordsLeft_q <= wordsLeft_d;
      inflight_q  <= inflight_d;
    end
  end

  fifo_skid_buffer #(
    .DATA_WIDTH (FIFO_DATA_WIDTH)
  ) skidBuffer (
    .clk        (clk),
    .reset      (reset),
    .enable_i   (clk_enable),
    .push_i     (inflight_q),
    .pushData_i (fifo_read_data),
    .pop_i      (out_valid && out_ready),
    .occ_o      (occ),
    .headData_o (out_data)
  );

  assign out_valid  = (occ != '0);
  assign busy       = (state_q != IDLE);
  assign words_left = wordsLeft_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// ---------------------------------------------------------------------------
// tb_fifo_burst_reader
// Drives fifo_burst_reader against a simple one-cycle-latency FIFO model and
// checks the stream contents, read strobes, counters and done pulse.
// ---------------------------------------------------------------------------
module tb_fifo_burst_reader;

  logic       clk = 1'b0;
  logic       reset, clk_enable, start, out_ready;
  logic [7:0] burst_len;
  logic       fifo_read, fifo_empty, out_valid, busy, done;
  logic [7:0] fifo_read_data = 8'd0;
  logic [7:0] out_data, words_left;

  logic [7:0] fifoMem [256];
  int         wrPtr = 0;
  int         rdPtr = 0;
  logic       flushReq = 1'b0;

  int         testsRun = 0;
  int         failures = 0;
  int         readsIssued = 0;
  int         acceptCount = 0;
  int         doneCount = 0;
  logic [7:0] expNext = 8'd0;

  typedef struct {
    logic       inStart;
    logic [7:0] inLen;
    logic       inReady;
    logic       expRead;
    logic       expValid;
    logic [7:0] expData;
    logic       expBusy;
    logic       expDone;
    logic [7:0] expWordsLeft;
  } vec_t;

  vec_t vecs [11];

  fifo_burst_reader #(
    .FIFO_DATA_WIDTH (8),
    .LEN_WIDTH       (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .clk_enable     (clk_enable),
    .start          (start),
    .burst_len      (burst_len),
    .fifo_read      (fifo_read),
    .fifo_read_data (fifo_read_data),
    .fifo_empty     (fifo_empty),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .busy           (busy),
    .done           (done),
    .words_left     (words_left)
  );

  always #5 clk = ~clk;

  // FIFO model: data appears on fifo_read_data the cycle after a read.
  assign fifo_empty = (wrPtr == rdPtr);

  always @(posedge clk) begin
    if (flushReq) begin
      rdPtr <= wrPtr;
    end else if (fifo_read) begin
      fifo_read_data <= fifoMem[rdPtr[7:0]];
      rdPtr          <= rdPtr + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [7:0] len, input logic rdy);
    start     = s;
    burst_len = len;
    out_ready = rdy;
  endtask

  task automatic loadWords(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      fifoMem[wrPtr[7:0]] = base + 8'(i);
      wrPtr++;
    end
  endtask

  task automatic resetCounters(input logic [7:0] firstWord);
    readsIssued = 0;
    acceptCount = 0;
    doneCount   = 0;
    expNext     = firstWord;
  endtask

  // Called at the negedge: looks at what the coming posedge will do.
  task automatic monitorStep();
    if (fifo_read) begin
      readsIssued++;
      checkOutput("noEmptyRead", 32'(fifo_empty), 32'd0);
    end
    if (!reset && clk_enable && out_valid && out_ready) begin
      checkOutput("streamData", 32'(out_data), 32'(expNext));
      expNext = expNext + 8'd1;
      acceptCount++;
    end
    if (done) doneCount++;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic advance();
    monitorStep();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  task automatic flushFifo();
    flushReq = 1'b1;
    tick();
    flushReq = 1'b0;
  endtask

  task automatic waitDone(input int maxCycles, input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < maxCycles && !seen; i++) begin
      settle();
      if (done) seen = 1'b1;
      advance();
    end
    checkOutput(name, 32'(seen), 32'd1);
  endtask

  initial begin
    // Burst of 8 from a FIFO holding 0..7, consumer always ready.
    vecs[0]  = '{1'b1, 8'd8, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 8'd8};
    vecs[2]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 8'd7};
    vecs[3]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 8'd0, 1'b1, 1'b0, 8'd6};
    vecs[4]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 8'd1, 1'b1, 1'b0, 8'd5};
    vecs[5]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 8'd2, 1'b1, 1'b0, 8'd4};
    vecs[6]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 8'd3, 1'b1, 1'b0, 8'd3};
    vecs[7]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 8'd4, 1'b1, 1'b0, 8'd2};
    vecs[8]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 8'd5, 1'b1, 1'b0, 8'd1};
    vecs[9]  = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 8'd6, 1'b1, 1'b0, 8'd0};
    vecs[10] = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 8'd7, 1'b1, 1'b0, 8'd0};

    reset      = 1'b1;
    clk_enable = 1'b1;
    applyStimulus(1'b0, 8'd0, 1'b1);
    loadWords(8'd0, 8);
    tick();
    tick();
    settle();
    checkOutput("rstRead", 32'(fifo_read), 32'd0);
    checkOutput("rstValid", 32'(out_valid), 32'd0);
    checkOutput("rstData", 32'(out_data), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstWordsLeft", 32'(words_left), 32'd0);
    advance();
    reset = 1'b0;

    // Table-driven burst of 8
    resetCounters(8'd0);
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].inStart, vecs[i].inLen, vecs[i].inReady);
      settle();
      checkOutput($sformatf("t1Read[%0d]", i), 32'(fifo_read), 32'(vecs[i].expRead));
      checkOutput($sformatf("t1Valid[%0d]", i), 32'(out_valid), 32'(vecs[i].expValid));
      if (vecs[i].expValid)
        checkOutput($sformatf("t1Data[%0d]", i), 32'(out_data), 32'(vecs[i].expData));
      checkOutput($sformatf("t1Busy[%0d]", i), 32'(busy), 32'(vecs[i].expBusy));
      checkOutput($sformatf("t1Done[%0d]", i), 32'(done), 32'(vecs[i].expDone));
      checkOutput($sformatf("t1WordsLeft[%0d]", i), 32'(words_left), 32'(vecs[i].expWordsLeft));
      advance();
    end
    waitDone(4, "t1DoneSeen");
    settle();
    checkOutput("t1IdleBusy", 32'(busy), 32'd0);
    advance();
    checkOutput("t1DonePulses", 32'(doneCount), 32'd1);
    checkOutput("t1Reads", 32'(readsIssued), 32'd8);
    checkOutput("t1Accepts", 32'(acceptCount), 32'd8);

    // Burst of 4 from a FIFO holding 10 words; a start mid-burst is ignored
    flushFifo();
    loadWords(8'd0, 10);
    resetCounters(8'd0);
    applyStimulus(1'b1, 8'd4, 1'b1);
    tick();
    applyStimulus(1'b0, 8'd0, 1'b1);
    tick();
    tick();
    applyStimulus(1'b1, 8'd2, 1'b1);
    tick();
    applyStimulus(1'b0, 8'd0, 1'b1);
    waitDone(20, "t2DoneSeen");
    tick();
    tick();
    settle();
    checkOutput("t2IdleBusy", 32'(busy), 32'd0);
    advance();
    checkOutput("t2Reads", 32'(readsIssued), 32'd4);
    checkOutput("t2Accepts", 32'(acceptCount), 32'd4);
    checkOutput("t2LastWord", 32'(expNext), 32'd4);
    checkOutput("t2FifoLeft", 32'(wrPtr - rdPtr), 32'd6);
    checkOutput("t2DonePulses", 32'(doneCount), 32'd1);

    // Zero-length burst, then start during the DONE cycle is ignored
    flushFifo();
    loadWords(8'd200, 2);
    resetCounters(8'd200);
    applyStimulus(1'b1, 8'd0, 1'b1);
    settle();
    checkOutput("t3StartBusy", 32'(busy), 32'd0);
    advance();
    applyStimulus(1'b1, 8'd3, 1'b1);
    settle();
    checkOutput("t3Done", 32'(done), 32'd1);
    checkOutput("t3DoneBusy", 32'(busy), 32'd1);
    checkOutput("t3DoneRead", 32'(fifo_read), 32'd0);
    advance();
    applyStimulus(1'b0, 8'd0, 1'b1);
    settle();
    checkOutput("t3AfterBusy", 32'(busy), 32'd0);
    checkOutput("t3AfterDone", 32'(done), 32'd0);
    checkOutput("t3AfterWordsLeft", 32'(words_left), 32'd0);
    advance();
    tick();
    tick();
    checkOutput("t3Reads", 32'(readsIssued), 32'd0);

    // Consumer stalls for 10 cycles: buffer fills to 3, reads stop
    flushFifo();
    loadWords(8'd20, 8);
    resetCounters(8'd20);
    applyStimulus(1'b1, 8'd8, 1'b1);
    tick();
    applyStimulus(1'b0, 8'd0, 1'b1);
    tick();
    tick();
    applyStimulus(1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 9; i++) tick();
    settle();
    checkOutput("t4StallRead", 32'(fifo_read), 32'd0);
    checkOutput("t4StallValid", 32'(out_valid), 32'd1);
    checkOutput("t4StallData", 32'(out_data), 32'd20);
    checkOutput("t4StallWordsLeft", 32'(words_left), 32'd5);
    checkOutput("t4Buffered", 32'(readsIssued - acceptCount), 32'd3);
    advance();
    applyStimulus(1'b0, 8'd0, 1'b1);
    waitDone(40, "t4DoneSeen");
    checkOutput("t4Accepts", 32'(acceptCount), 32'd8);
    checkOutput("t4LastWord", 32'(expNext), 32'd28);
    checkOutput("t4Reads", 32'(readsIssued), 32'd8);

    // FIFO runs dry after 2 of 5 words, then is refilled
    flushFifo();
    loadWords(8'd40, 2);
    resetCounters(8'd40);
    applyStimulus(1'b1, 8'd5, 1'b1);
    tick();
    applyStimulus(1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 8; i++) tick();
    settle();
    checkOutput("t5StallBusy", 32'(busy), 32'd1);
    checkOutput("t5StallRead", 32'(fifo_read), 32'd0);
    checkOutput("t5StallWordsLeft", 32'(words_left), 32'd3);
    checkOutput("t5StallReads", 32'(readsIssued), 32'd2);
    checkOutput("t5StallAccepts", 32'(acceptCount), 32'd2);
    advance();
    loadWords(8'd42, 3);
    waitDone(30, "t5DoneSeen");
    checkOutput("t5Accepts", 32'(acceptCount), 32'd5);
    checkOutput("t5Reads", 32'(readsIssued), 32'd5);
    checkOutput("t5LastWord", 32'(expNext), 32'd45);

    // Reset mid-burst while a FIFO word is in flight
    flushFifo();
    loadWords(8'd60, 10);
    resetCounters(8'd60);
    applyStimulus(1'b1, 8'd6, 1'b1);
    tick();
    applyStimulus(1'b0, 8'd0, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    checkOutput("t6RstRead", 32'(fifo_read), 32'd0);
    checkOutput("t6RstValid", 32'(out_valid), 32'd0);
    checkOutput("t6RstData", 32'(out_data), 32'd0);
    checkOutput("t6RstBusy", 32'(busy), 32'd0);
    checkOutput("t6RstDone", 32'(done), 32'd0);
    checkOutput("t6RstWordsLeft", 32'(words_left), 32'd0);
    advance();
    flushFifo();
    loadWords(8'd80, 3);
    resetCounters(8'd80);
    applyStimulus(1'b1, 8'd3, 1'b1);
    tick();
    applyStimulus(1'b0, 8'd0, 1'b1);
    waitDone(20, "t6DoneSeen");
    checkOutput("t6Accepts", 32'(acceptCount), 32'd3);
    checkOutput("t6LastWord", 32'(expNext), 32'd83);
    checkOutput("t6Reads", 32'(readsIssued), 32'd3);

    // Clock enable low for 3 cycles mid-burst
    flushFifo();
    loadWords(8'd100, 6);
    resetCounters(8'd100);
    applyStimulus(1'b1, 8'd6, 1'b1);
    tick();
    applyStimulus(1'b0, 8'd0, 1'b1);
    tick();
    tick();
    clk_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      checkOutput($sformatf("t7FrozenRead[%0d]", i), 32'(fifo_read), 32'd0);
      checkOutput($sformatf("t7FrozenValid[%0d]", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("t7FrozenData[%0d]", i), 32'(out_data), 32'd100);
      checkOutput($sformatf("t7FrozenWordsLeft[%0d]", i), 32'(words_left), 32'd4);
      checkOutput($sformatf("t7FrozenBusy[%0d]", i), 32'(busy), 32'd1);
      checkOutput($sformatf("t7FrozenDone[%0d]", i), 32'(done), 32'd0);
      advance();
    end
    clk_enable = 1'b1;
    settle();
    checkOutput("t7ResumeRead", 32'(fifo_read), 32'd1);
    checkOutput("t7ResumeData", 32'(out_data), 32'd100);
    checkOutput("t7ResumeWordsLeft", 32'(words_left), 32'd4);
    advance();
    waitDone(30, "t7DoneSeen");
    checkOutput("t7Accepts", 32'(acceptCount), 32'd6);
    checkOutput("t7LastWord", 32'(expNext), 32'd106);
    checkOutput("t7Reads", 32'(readsIssued), 32'd6);

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
